cluster_collector: RTL and testbench

Collects the per-pass winners of the cluster priority encoder into one fixed-size cluster list per frame. Each frame is MXPASS consecutive clocks tagged pass 0..MXPASS-1. The block accepts each valid {cnt, adr} result into the next free slot and publishes the completed list with a one-cycle strobe. It sits directly downstream of the priority encoder and feeds the trigger-link formatter.

---
 rtl/cluster_collector.sv | 201 ++++++++++++++++++++
 tb/tb_cluster_collector.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cluster_collector.sv
// cluster_collector
//
// Gathers the per-pass winners of the cluster priority encoder into a fixed
// list of MXCLUSTERS slots per frame and publishes the completed list with a
// one-cycle strobe. A frame is MXPASS consecutive clocks tagged 0..MXPASS-1.
//
// Ports
//   clock            system clock
//   reset_n          asynchronous active-low reset
//   pass_i           pass tag of the current encoder result
//   vpf_i            encoder result valid
//   adr_i            encoder cluster address
//   cnt_i            encoder cluster size count
//   clusters_o       published slots, slot k at [k*W +: W], W = MXCNTB+MXKEYBITS,
//                    packed {cnt, adr}; unused slots read {0, all-ones adr}
//   cluster_count_o  number of valid slots in the published frame
//   frame_valid_o    one-cycle strobe when a new list is published
//   overflow_o       published frame dropped at least one valid result
//   sync_err_o       sticky pass-sequence error, cleared only by reset
module cluster_collector #(
  parameter int MXKEYBITS  = 8,
  parameter int MXCNTB     = 3,
  parameter int MXCLUSTERS = 4,
  parameter int MXPASS     = 8
) (
  input  logic                                       clock,
  input  logic                                       reset_n,
  input  logic [2:0]                                 pass_i,
  input  logic                                       vpf_i,
  input  logic [MXKEYBITS-1:0]                       adr_i,
  input  logic [MXCNTB-1:0]                          cnt_i,
  output logic [MXCLUSTERS*(MXCNTB+MXKEYBITS)-1:0]   clusters_o,
  output logic [$clog2(MXCLUSTERS+1)-1:0]            cluster_count_o,
  output logic                                       frame_valid_o,
  output logic                                       overflow_o,
  output logic                                       sync_err_o
);

  localparam int W  = MXCNTB + MXKEYBITS;
  localparam int CW = $clog2(MXCLUSTERS + 1);

  localparam logic [W-1:0]  EMPTY    = {{MXCNTB{1'b0}}, {MXKEYBITS{1'b1}}};
  localparam logic [2:0]    LAST_TAG = 3'(MXPASS - 1);
  localparam logic [CW-1:0] FULL     = CW'(MXCLUSTERS);

  typedef enum logic {
    SEEK,
    COLLECT
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    tag_q, tag_d;
  logic [CW-1:0] wr_ptr_q, wr_ptr_d;
  logic          ovf_q, ovf_d;
  logic          serr_q, serr_d;
  logic          pub_q, pub_d;

  logic          take;
  logic          start;
  logic          wr_en;
  logic [CW-1:0] wr_idx;
  logic [CW-1:0] base_ptr;
  logic          base_ovf;
  logic [2:0]    exp_tag;

  logic [W-1:0]              slot_q [MXCLUSTERS];
  logic [MXCLUSTERS*W-1:0]   pub_data;

  logic [MXCLUSTERS*W-1:0]   clusters_q;
  logic [CW-1:0]             count_q;
  logic                      fv_q;
  logic                      ovf_out_q;

  // After the last pass the sequence wraps back to tag 0.
  assign exp_tag = (tag_q == LAST_TAG) ? 3'd0 : tag_q + 3'd1;

  always_comb begin
    state_d  = state_q;
    tag_d    = tag_q;
    wr_ptr_d = wr_ptr_q;
    ovf_d    = ovf_q;
    serr_d   = serr_q;
    pub_d    = 1'b0;
    take     = 1'b0;
    start    = 1'b0;
    wr_en    = 1'b0;
    wr_idx   = '0;
    base_ptr = wr_ptr_q;
    base_ovf = ovf_q;

    case (state_q)
      SEEK: begin
        if (pass_i == 3'd0) begin
          take    = 1'b1;
          start   = 1'b1;
          state_d = COLLECT;
        end
      end
      COLLECT: begin
        if (pass_i == exp_tag) begin
          take  = 1'b1;
          start = (pass_i == 3'd0);
        end else begin
          serr_d = 1'b1;
          if (pass_i == 3'd0) begin
            // A fresh tag 0 restarts the frame on the spot.
            take  = 1'b1;
            start = 1'b1;
          end else begin
            state_d  = SEEK;
            wr_ptr_d = '0;
            ovf_d    = 1'b0;
          end
        end
      end
      default: state_d = SEEK;
    endcase

    if (take) begin
      tag_d = pass_i;
      // Publication happens on the edge after the last pass is captured,
      // so it lines up with the next frame's pass 0.
      pub_d = (pass_i == LAST_TAG);
      if (start) begin
        base_ptr = '0;
        base_ovf = 1'b0;
      end
      wr_ptr_d = base_ptr;
      ovf_d    = base_ovf;
      if (vpf_i) begin
        if (base_ptr < FULL) begin
          wr_en    = 1'b1;
          wr_idx   = base_ptr;
          wr_ptr_d = base_ptr + CW'(1);
        end else begin
          ovf_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= SEEK;
      tag_q    <= '0;
      wr_ptr_q <= '0;
      ovf_q    <= 1'b0;
      serr_q   <= 1'b0;
      pub_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      tag_q    <= tag_d;
      wr_ptr_q <= wr_ptr_d;
      ovf_q    <= ovf_d;
      serr_q   <= serr_d;
      pub_q    <= pub_d;
    end
  end

  // Working slots carry data only; validity is tracked by wr_ptr_q.
  always_ff @(posedge clock) begin
    for (int k = 0; k < MXCLUSTERS; k++) begin
      if (wr_en && (wr_idx == CW'(k))) begin
        slot_q[k] <= {cnt_i, adr_i};
      end
    end
  end

  // Slots beyond the write pointer may hold stale data from older frames.
  always_comb begin
    pub_data = '0;
    for (int k = 0; k < MXCLUSTERS; k++) begin
      pub_data[k*W +: W] = (CW'(k) < wr_ptr_q) ? slot_q[k] : EMPTY;
    end
  end

  // Output registers load from the completed working buffer while the
  // working buffer may already be restarting for the next frame.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      clusters_q <= {MXCLUSTERS{EMPTY}};
      count_q    <= '0;
      fv_q       <= 1'b0;
      ovf_out_q  <= 1'b0;
    end else begin
      fv_q <= pub_q;
      if (pub_q) begin
        clusters_q <= pub_data;
        count_q    <= wr_ptr_q;
        ovf_out_q  <= ovf_q;
      end
    end
  end

  assign clusters_o      = clusters_q;
  assign cluster_count_o = count_q;
  assign frame_valid_o   = fv_q;
  assign overflow_o      = ovf_out_q;
  assign sync_err_o      = serr_q;

endmodule

// File: tb/tb_cluster_collector.sv
module tb_cluster_collector;

  localparam int KB  = 8;
  localparam int CB  = 3;
  localparam int NC  = 4;
  localparam int NP  = 8;
  localparam int W   = KB + CB;
  localparam int CLW = NC * W;
  localparam logic [W-1:0] EMPTY = {3'b000, 8'hFF};

  logic           clock = 1'b0;
  logic           reset_n = 1'b1;
  logic [2:0]     pass_i = 3'd0;
  logic           vpf_i = 1'b0;
  logic [KB-1:0]  adr_i = '0;
  logic [CB-1:0]  cnt_i = '0;
  logic [CLW-1:0] clusters_o;
  logic [2:0]     cluster_count_o;
  logic           frame_valid_o;
  logic           overflow_o;
  logic           sync_err_o;

  cluster_collector #(
    .MXKEYBITS(KB), .MXCNTB(CB), .MXCLUSTERS(NC), .MXPASS(NP)
  ) dut (
    .clock(clock), .reset_n(reset_n), .pass_i(pass_i), .vpf_i(vpf_i),
    .adr_i(adr_i), .cnt_i(cnt_i), .clusters_o(clusters_o),
    .cluster_count_o(cluster_count_o), .frame_valid_o(frame_valid_o),
    .overflow_o(overflow_o), .sync_err_o(sync_err_o)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int             cyc;
    logic [CLW-1:0] cl;
    logic [2:0]     n;
    logic           ov;
  } rec_t;
  rec_t mon_q[$];
  rec_t mrec;
  rec_t exp_q[$];

  // Every strobe seen by the bench, with the cycle it appeared in.
  always @(negedge clock) begin
    if (frame_valid_o !== 1'b0) begin
      mrec.cyc = cyc;
      mrec.cl  = clusters_o;
      mrec.n   = cluster_count_o;
      mrec.ov  = overflow_o;
      mon_q.push_back(mrec);
    end
  end

  logic          f_vpf [NP];
  logic [KB-1:0] f_adr [NP];
  logic [CB-1:0] f_cnt [NP];

  task automatic drive_cycle(input logic [2:0] p, input logic v,
                             input logic [KB-1:0] a, input logic [CB-1:0] c);
    pass_i = p; vpf_i = v; adr_i = a; cnt_i = c;
    @(posedge clock);
    #1;
  endtask

  task automatic clear_frame();
    for (int p = 0; p < NP; p++) begin
      f_vpf[p] = 1'b0; f_adr[p] = '0; f_cnt[p] = '0;
    end
  endtask

  task automatic gen_frame(input int nhits);
    int placed;
    int p;
    clear_frame();
    placed = 0;
    while (placed < nhits) begin
      p = $urandom_range(0, NP - 1);
      if (!f_vpf[p]) begin
        f_vpf[p] = 1'b1;
        f_adr[p] = KB'($urandom);
        f_cnt[p] = CB'($urandom);
        placed++;
      end
    end
  endtask

  // Reference: hits in pass order, first NC kept, surplus flags overflow.
  // The strobe is due NP cycles after the pass-0 sample.
  task automatic model_frame(input int c0);
    rec_t e;
    int hits;
    e.cyc = c0 + NP;
    e.cl  = {NC{EMPTY}};
    hits  = 0;
    for (int p = 0; p < NP; p++) begin
      if (f_vpf[p]) begin
        if (hits < NC) e.cl[hits*W +: W] = {f_cnt[p], f_adr[p]};
        hits++;
      end
    end
    e.ov = (hits > NC);
    e.n  = 3'((hits > NC) ? NC : hits);
    exp_q.push_back(e);
  endtask

  task automatic drive_frame();
    int c0;
    c0 = 0;
    for (int p = 0; p < NP; p++) begin
      drive_cycle(3'(p), f_vpf[p], f_adr[p], f_cnt[p]);
      if (p == 0) c0 = cyc;
    end
    model_frame(c0);
  endtask

  task automatic flush();
    drive_cycle(3'd0, 1'b0, '0, '0);
    @(negedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    for (int i = 0; i < 2; i++) drive_cycle(3'($urandom), 1'($urandom), KB'($urandom), CB'($urandom));
    reset_n = 1'b1;
    pass_i = 3'd3; vpf_i = 1'b0;
    mon_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    #2 reset_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive_cycle(3'($urandom), 1'($urandom), KB'($urandom), CB'($urandom));
      checks++;
      if ({clusters_o, cluster_count_o, frame_valid_o, overflow_o, sync_err_o} !==
          {{NC{EMPTY}}, 3'd0, 1'b0, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL reset_values cyc%0d got cl=%h n=%0d fv=%b ov=%b se=%b",
                 i, clusters_o, cluster_count_o, frame_valid_o, overflow_o, sync_err_o);
      end
    end
    reset_n = 1'b1;
    pass_i = 3'd3;
    checks++;
    if (mon_q.size() != 0) begin
      errors++;
      $display("FAIL reset_strobe got %0d strobes want 0", mon_q.size());
    end
  endtask

  task automatic test_sparse();
    do_reset();
    clear_frame();
    f_vpf[1] = 1'b1; f_adr[1] = 8'd5;  f_cnt[1] = 3'd2;
    f_vpf[3] = 1'b1; f_adr[3] = 8'd17; f_cnt[3] = 3'd7;
    drive_frame();
    flush();
    checks++;
    if (mon_q.size() != 1) begin
      errors++;
      $display("FAIL sparse_strobes got %0d want 1", mon_q.size());
    end else begin
      checks++;
      if ({mon_q[0].cl, mon_q[0].n, mon_q[0].ov} !==
          {EMPTY, EMPTY, 3'd7, 8'd17, 3'd2, 8'd5, 3'd2, 1'b0}) begin
        errors++;
        $display("FAIL sparse_data got cl=%h n=%0d ov=%b want slots {2,5},{7,17} n=2 ov=0",
                 mon_q[0].cl, mon_q[0].n, mon_q[0].ov);
      end
      checks++;
      if (mon_q[0].cyc != exp_q[0].cyc) begin
        errors++;
        $display("FAIL sparse_latency got cyc %0d want %0d", mon_q[0].cyc, exp_q[0].cyc);
      end
    end
    // Outputs hold after the strobe.
    drive_cycle(3'd1, 1'b0, '0, '0);
    checks++;
    if ({frame_valid_o, cluster_count_o, clusters_o[W-1:0]} !== {1'b0, 3'd2, 3'd2, 8'd5}) begin
      errors++;
      $display("FAIL sparse_hold got fv=%b n=%0d slot0=%h want fv=0 n=2 slot0=%h",
               frame_valid_o, cluster_count_o, clusters_o[W-1:0], {3'd2, 8'd5});
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int p = 0; p < NP; p++) begin
      f_vpf[p] = 1'b1; f_adr[p] = 8'(p); f_cnt[p] = 3'd1;
    end
    drive_frame();
    clear_frame();
    drive_frame();
    flush();
    checks++;
    if (mon_q.size() != 2) begin
      errors++;
      $display("FAIL overflow_strobes got %0d want 2", mon_q.size());
    end else begin
      checks++;
      if ({mon_q[0].cl, mon_q[0].n, mon_q[0].ov} !==
          {3'd1, 8'd3, 3'd1, 8'd2, 3'd1, 8'd1, 3'd1, 8'd0, 3'd4, 1'b1}) begin
        errors++;
        $display("FAIL overflow_full got cl=%h n=%0d ov=%b want adr 0..3 n=4 ov=1",
                 mon_q[0].cl, mon_q[0].n, mon_q[0].ov);
      end
      checks++;
      if ({mon_q[1].cl, mon_q[1].n, mon_q[1].ov} !== {{NC{EMPTY}}, 3'd0, 1'b0}) begin
        errors++;
        $display("FAIL overflow_empty got cl=%h n=%0d ov=%b want empty n=0 ov=0",
                 mon_q[1].cl, mon_q[1].n, mon_q[1].ov);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    gen_frame(1); drive_frame();
    gen_frame(0); drive_frame();
    gen_frame(4); drive_frame();
    flush();
    checks++;
    if (mon_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL b2b_strobes got %0d want %0d", mon_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++) begin
      checks++;
      if ({mon_q[i].cl, mon_q[i].n, mon_q[i].ov, mon_q[i].cyc} !==
          {exp_q[i].cl, exp_q[i].n, exp_q[i].ov, exp_q[i].cyc}) begin
        errors++;
        $display("FAIL b2b_frame%0d got cl=%h n=%0d ov=%b cyc=%0d want cl=%h n=%0d ov=%b cyc=%0d",
                 i, mon_q[i].cl, mon_q[i].n, mon_q[i].ov, mon_q[i].cyc,
                 exp_q[i].cl, exp_q[i].n, exp_q[i].ov, exp_q[i].cyc);
      end
    end
    if (mon_q.size() >= 3) begin
      checks++;
      if ((mon_q[1].cyc - mon_q[0].cyc != NP) || (mon_q[2].cyc - mon_q[1].cyc != NP)) begin
        errors++;
        $display("FAIL b2b_spacing got %0d,%0d want %0d", mon_q[1].cyc - mon_q[0].cyc,
                 mon_q[2].cyc - mon_q[1].cyc, NP);
      end
    end
  endtask

  task automatic test_seq_error();
    do_reset();
    drive_cycle(3'd0, 1'b1, 8'h11, 3'd1);
    drive_cycle(3'd1, 1'b0, 8'h00, 3'd0);
    drive_cycle(3'd2, 1'b1, 8'h22, 3'd2);
    drive_cycle(3'd5, 1'b1, 8'h55, 3'd5);
    checks++;
    if (sync_err_o !== 1'b1) begin
      errors++;
      $display("FAIL seq_err_set got %b want 1", sync_err_o);
    end
    gen_frame(2); drive_frame();
    flush();
    checks++;
    if ((mon_q.size() != 1) || (exp_q.size() != 1)) begin
      errors++;
      $display("FAIL seq_skip_strobes got %0d want 1", mon_q.size());
    end else begin
      checks++;
      if ({mon_q[0].cl, mon_q[0].n, mon_q[0].ov, mon_q[0].cyc} !==
          {exp_q[0].cl, exp_q[0].n, exp_q[0].ov, exp_q[0].cyc}) begin
        errors++;
        $display("FAIL seq_skip_frame got cl=%h n=%0d cyc=%0d want cl=%h n=%0d cyc=%0d",
                 mon_q[0].cl, mon_q[0].n, mon_q[0].cyc, exp_q[0].cl, exp_q[0].n, exp_q[0].cyc);
      end
    end
    checks++;
    if (sync_err_o !== 1'b1) begin
      errors++;
      $display("FAIL seq_err_sticky got %b want 1", sync_err_o);
    end

    do_reset();
    checks++;
    if (sync_err_o !== 1'b0) begin
      errors++;
      $display("FAIL seq_err_cleared got %b want 0", sync_err_o);
    end
    drive_cycle(3'd0, 1'b1, 8'hA0, 3'd3);
    drive_cycle(3'd1, 1'b1, 8'hA1, 3'd4);
    gen_frame(3); drive_frame();
    flush();
    checks++;
    if ((mon_q.size() != 1) || (exp_q.size() != 1)) begin
      errors++;
      $display("FAIL seq_restart_strobes got %0d want 1", mon_q.size());
    end else begin
      checks++;
      if ({mon_q[0].cl, mon_q[0].n, mon_q[0].ov, mon_q[0].cyc} !==
          {exp_q[0].cl, exp_q[0].n, exp_q[0].ov, exp_q[0].cyc}) begin
        errors++;
        $display("FAIL seq_restart_frame got cl=%h n=%0d cyc=%0d want cl=%h n=%0d cyc=%0d",
                 mon_q[0].cl, mon_q[0].n, mon_q[0].cyc, exp_q[0].cl, exp_q[0].n, exp_q[0].cyc);
      end
    end
    checks++;
    if (sync_err_o !== 1'b1) begin
      errors++;
      $display("FAIL seq_restart_err got %b want 1", sync_err_o);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    gen_frame(3); drive_frame();
    gen_frame(4);
    for (int p = 0; p < 4; p++) drive_cycle(3'(p), f_vpf[p], f_adr[p], f_cnt[p]);
    pass_i = 3'd4; vpf_i = 1'b1; adr_i = 8'h44; cnt_i = 3'd4;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({clusters_o, cluster_count_o, frame_valid_o, overflow_o, sync_err_o} !==
        {{NC{EMPTY}}, 3'd0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL midreset_clear got cl=%h n=%0d fv=%b ov=%b se=%b",
               clusters_o, cluster_count_o, frame_valid_o, overflow_o, sync_err_o);
    end
    @(posedge clock); #1;
    drive_cycle(3'd5, 1'b1, 8'h45, 3'd5);
    reset_n = 1'b1;
    drive_cycle(3'd6, 1'b1, 8'h46, 3'd6);
    drive_cycle(3'd7, 1'b1, 8'h47, 3'd7);
    gen_frame($urandom_range(0, 6)); drive_frame();
    flush();
    checks++;
    if (mon_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL midreset_strobes got %0d want %0d", mon_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++) begin
      checks++;
      if ({mon_q[i].cl, mon_q[i].n, mon_q[i].ov, mon_q[i].cyc} !==
          {exp_q[i].cl, exp_q[i].n, exp_q[i].ov, exp_q[i].cyc}) begin
        errors++;
        $display("FAIL midreset_frame%0d got cl=%h n=%0d cyc=%0d want cl=%h n=%0d cyc=%0d",
                 i, mon_q[i].cl, mon_q[i].n, mon_q[i].cyc, exp_q[i].cl, exp_q[i].n, exp_q[i].cyc);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int f = 0; f < 12; f++) begin
      gen_frame($urandom_range(0, NP));
      drive_frame();
    end
    flush();
    checks++;
    if (mon_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL random_strobes got %0d want %0d", mon_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++) begin
      checks++;
      if ({mon_q[i].cl, mon_q[i].n, mon_q[i].ov, mon_q[i].cyc} !==
          {exp_q[i].cl, exp_q[i].n, exp_q[i].ov, exp_q[i].cyc}) begin
        errors++;
        $display("FAIL random_frame%0d got cl=%h n=%0d ov=%b cyc=%0d want cl=%h n=%0d ov=%b cyc=%0d",
                 i, mon_q[i].cl, mon_q[i].n, mon_q[i].ov, mon_q[i].cyc,
                 exp_q[i].cl, exp_q[i].n, exp_q[i].ov, exp_q[i].cyc);
      end
    end
    checks++;
    if (sync_err_o !== 1'b0) begin
      errors++;
      $display("FAIL random_no_sync_err got %b want 0", sync_err_o);
    end
  endtask

  initial begin
    test_reset();
    test_sparse();
    test_overflow();
    test_back_to_back();
    test_seq_error();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
